// File: rtl/irq_pkg.sv
// Shared constants and types for the board interrupt controller.
// Source indices name the fixed peripheral lines; the rest are spares.
package irq_pkg;

   localparam int IRQ_NUM_SRC = 16;

   localparam int IRQ_CAN_A_U = 0;
   localparam int IRQ_CAN_A_S = 1;
   localparam int IRQ_CAN_B_U = 2;
   localparam int IRQ_CAN_B_S = 3;
   localparam int IRQ_BUS1553 = 4;
   localparam int IRQ_LVDS    = 5;  // reserved for the future LVDS link

   typedef logic [IRQ_NUM_SRC-1:0] irq_vec_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// ARM-side bus of the interrupt controller: configuration, W1C clear and status.
// master = ARM/register side, slave = irq_ctrl.
interface irq_ctrl_if import irq_pkg::*; #(
   parameter int NUM_SRC = IRQ_NUM_SRC,
   parameter int ID_W    = $clog2(NUM_SRC)
);
   logic [NUM_SRC-1:0] cfg_edge;
   logic [NUM_SRC-1:0] cfg_mask;
   logic               clr_valid;
   logic [NUM_SRC-1:0] clr_bits;
   logic [NUM_SRC-1:0] pending_o;
   logic [NUM_SRC-1:0] overrun_o;
   logic [NUM_SRC-1:0] ARM_Interrupt;
   logic               irq_o;
   logic [ID_W-1:0]    irq_id_o;

   modport master (
      output cfg_edge, cfg_mask, clr_valid, clr_bits,
      input  pending_o, overrun_o, ARM_Interrupt, irq_o, irq_id_o
   );

   modport slave (
      input  cfg_edge, cfg_mask, clr_valid, clr_bits,
      output pending_o, overrun_o, ARM_Interrupt, irq_o, irq_id_o
   );
endinterface

// File: rtl/irq_sync_edge.sv
// One source: SYNC_STAGES-flop synchroniser plus edge-history flop.
// s_o is the synchronised level, rise_o is high for one cycle after each rising edge.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic src_i,
   output logic s_o,
   output logic rise_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   hist_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], src_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // History resets low, so a line held high across reset yields one edge.
   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky pending per source, W1C clear, overrun flags,
// masked ARM vector, aggregated irq_o and lowest-index priority ID.
module irq_ctrl import irq_pkg::*; #(
   parameter int NUM_SRC     = IRQ_NUM_SRC,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_irq,
   irq_ctrl_if.slave          bus
);
   logic [NUM_SRC-1:0] s_w;
   logic [NUM_SRC-1:0] rise_w;
   logic [NUM_SRC-1:0] ev_w;
   logic [NUM_SRC-1:0] clr_w;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] overrun_q, overrun_d;
   logic [NUM_SRC-1:0] arm_w;
   logic [ID_W-1:0]    id_w;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .rst    (rst),
         .src_i  (src_irq[g]),
         .s_o    (s_w[g]),
         .rise_o (rise_w[g])
      );
   end

   assign ev_w  = (bus.cfg_edge & rise_w) | (~bus.cfg_edge & s_w);
   assign clr_w = {NUM_SRC{bus.clr_valid}} & bus.clr_bits;

   // A new event beats a simultaneous clear; overrun only counts edge-mode events.
   assign pending_d = ev_w | (pending_q & ~clr_w);
   assign overrun_d = (ev_w & bus.cfg_edge & pending_q & ~clr_w) | (overrun_q & ~clr_w);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign arm_w = pending_q & bus.cfg_mask;

   // Scan downwards so the lowest set index is the last one written.
   always_comb begin
      id_w = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (arm_w[i]) id_w = ID_W'(i);
      end
   end

   assign bus.pending_o     = pending_q;
   assign bus.overrun_o     = overrun_q;
   assign bus.ARM_Interrupt = arm_w;
   assign bus.irq_o         = |arm_w;
   assign bus.irq_id_o      = id_w;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_irq_ctrl;
   import irq_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   irq_vec_t src;
   int       checks   = 0;
   int       failures = 0;

   irq_ctrl_if #(.NUM_SRC(16)) bus ();

   irq_ctrl #(
      .NUM_SRC     (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .src_irq (src),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_out();
      return {11'd0, bus.pending_o, bus.overrun_o, bus.ARM_Interrupt, bus.irq_o, bus.irq_id_o};
   endfunction

   task automatic clear(input irq_vec_t bits);
      bus.clr_valid = 1'b1;
      bus.clr_bits  = bits;
      cyc(1);
      bus.clr_valid = 1'b0;
      bus.clr_bits  = '0;
   endtask

   initial begin
      rst           = 1'b1;
      src           = '0;
      bus.cfg_edge  = 16'hFFFD;  // source 1 level, all others edge
      bus.cfg_mask  = 16'hFFFF;
      bus.clr_valid = 1'b0;
      bus.clr_bits  = '0;

      // reset and idle
      cyc(2);
      chk("reset_all", all_out(), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("idle_all", all_out(), 64'd0);
      end

      // source 4 edge: two-cycle sync latency, then W1C
      src[IRQ_BUS1553] = 1'b1;
      cyc(1);
      chk("s4_lat1", bus.pending_o, 16'h0000);
      cyc(1);
      chk("s4_lat2", bus.pending_o, 16'h0000);
      cyc(1);
      chk("s4_pend", bus.pending_o, 16'h0010);
      chk("s4_irq", bus.irq_o, 1'b1);
      chk("s4_id", bus.irq_id_o, 4'd4);
      chk("s4_arm", bus.ARM_Interrupt, 16'h0010);
      src[IRQ_BUS1553] = 1'b0;
      clear(16'h0010);
      chk("s4_clr_pend", bus.pending_o, 16'h0000);
      chk("s4_clr_irq", bus.irq_o, 1'b0);
      chk("s4_ovr", bus.overrun_o, 16'h0000);

      // source 1 level: clear while high does not stick
      src[IRQ_CAN_A_S] = 1'b1;
      cyc(3);
      chk("s1_pend", bus.pending_o, 16'h0002);
      clear(16'h0002);
      chk("s1_clr_high", bus.pending_o, 16'h0002);
      src[IRQ_CAN_A_S] = 1'b0;
      cyc(2);
      chk("s1_after_drop", bus.pending_o, 16'h0002);
      clear(16'h0002);
      chk("s1_clr_low", bus.pending_o, 16'h0000);
      chk("s1_ovr", bus.overrun_o, 16'h0000);

      // priority and masking with sources 2 and 3
      src[IRQ_CAN_B_U] = 1'b1;
      src[IRQ_CAN_B_S] = 1'b1;
      cyc(3);
      chk("p23_pend", bus.pending_o, 16'h000C);
      chk("p23_id", bus.irq_id_o, 4'd2);
      clear(16'h0004);
      chk("p3_pend", bus.pending_o, 16'h0008);
      chk("p3_id", bus.irq_id_o, 4'd3);
      chk("p3_irq", bus.irq_o, 1'b1);
      bus.cfg_mask = 16'hFFF7;
      #1;
      chk("mask3_irq", bus.irq_o, 1'b0);
      chk("mask3_arm", bus.ARM_Interrupt, 16'h0000);
      chk("mask3_id", bus.irq_id_o, 4'd0);
      chk("mask3_pend", bus.pending_o, 16'h0008);
      bus.cfg_mask = 16'hFFFF;
      #1;
      chk("unmask3_irq", bus.irq_o, 1'b1);
      chk("unmask3_id", bus.irq_id_o, 4'd3);
      cyc(1);
      src = '0;
      clear(16'h0008);
      chk("p3_clr", bus.pending_o, 16'h0000);

      // source 0 overrun, then clear coinciding with a third edge
      src[IRQ_CAN_A_U] = 1'b1;
      cyc(3);
      chk("s0_pend", bus.pending_o, 16'h0001);
      chk("s0_no_ovr", bus.overrun_o, 16'h0000);
      src[IRQ_CAN_A_U] = 1'b0;
      cyc(2);
      src[IRQ_CAN_A_U] = 1'b1;
      cyc(3);
      chk("s0_ovr_set", bus.overrun_o, 16'h0001);
      chk("s0_ovr_pend", bus.pending_o, 16'h0001);
      src[IRQ_CAN_A_U] = 1'b0;
      cyc(2);
      src[IRQ_CAN_A_U] = 1'b1;
      cyc(2);
      clear(16'h0001);
      chk("s0_set_wins", bus.pending_o, 16'h0001);
      chk("s0_ovr_clr", bus.overrun_o, 16'h0000);

      // reset mid-clear with pending 0x1F and overrun set
      src = '0;
      cyc(3);
      src = 16'h001F;
      cyc(3);
      chk("pre_rst_pend", bus.pending_o, 16'h001F);
      chk("pre_rst_ovr", bus.overrun_o, 16'h0001);
      rst           = 1'b1;
      src           = 16'h0004;
      bus.clr_valid = 1'b1;
      bus.clr_bits  = 16'hFFFF;
      cyc(1);
      chk("rst_all", all_out(), 64'd0);
      bus.clr_valid = 1'b0;
      bus.clr_bits  = '0;
      cyc(1);
      rst = 1'b0;

      // source 2 held high across reset release: exactly one edge event
      cyc(2);
      chk("rel_lat", bus.pending_o, 16'h0000);
      cyc(1);
      chk("rel_pend", bus.pending_o, 16'h0004);
      chk("rel_id", bus.irq_id_o, 4'd2);
      chk("rel_ovr", bus.overrun_o, 16'h0000);
      clear(16'h0004);
      chk("rel_clr", bus.pending_o, 16'h0000);
      cyc(3);
      chk("rel_once", all_out(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
